pll_reset_sequencer: RTL and testbench

//   Drives the RESET pin of the Gowin PLL wrapper and consumes its LOCK output.

---
 rtl/pll_seq_pkg.sv | 20 ++
 rtl/pll_reset_sequencer_if.sv | 44 ++++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_reset_sequencer.sv | 128 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the PLL reset sequencer: the sequencer state
//   encoding and the default cycle-count constants for a 50 MHz oscillator.
//   No ports; imported by the interface and the sequencer top.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_RST_CYCLES    = 64;
    localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms at 50 MHz
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_RETRY_W       = 8;

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Bundles the PLL-facing and system-facing signals of the reset sequencer.
//   Signals:
//     pll_lock     PLL LOCK, asynchronous to clk
//     soft_rst     1-cycle pulse requesting a full re-sequence
//     pll_reset    drives PLL RESET, active-high
//     sys_rst_n    downstream reset, active-low, clk domain
//     locked       high while the sequencer is in RUN
//     timeout_err  sticky lock-timeout flag
//     event_cnt    saturating count of timeouts and lock losses
//   Modports: slave = sequencer side, master = PLL/system side.
interface pll_reset_sequencer_if
    import pll_seq_pkg::*;
#(
    parameter int RETRY_W = DEF_RETRY_W
);
    logic               pll_lock;
    logic               soft_rst;
    logic               pll_reset;
    logic               sys_rst_n;
    logic               locked;
    logic               timeout_err;
    logic [RETRY_W-1:0] event_cnt;

    modport slave (
        input  pll_lock,
        input  soft_rst,
        output pll_reset,
        output sys_rst_n,
        output locked,
        output timeout_err,
        output event_cnt
    );

    modport master (
        output pll_lock,
        output soft_rst,
        input  pll_reset,
        input  sys_rst_n,
        input  locked,
        input  timeout_err,
        input  event_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic two-flop synchronizer for a single-bit level signal.
//   Ports:
//     clk    destination-domain clock
//     rst_n  async active-low reset, loads RESET_VAL into both flops
//     d      asynchronous input
//     q      synchronized output, two destination cycles of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            // p0: may go metastable; p1: resolved copy
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Holds the PLL in reset, waits for lock with timeout and retry, qualifies
//   lock as stable for a number of consecutive cycles and only then releases
//   the system reset. Lock loss in RUN triggers a counted full re-sequence.
//   Ports:
//     clk    free-running oscillator clock (also the PLL reference)
//     rst_n  async active-low reset; pll_reset goes high with no clock
//     bus    slave side of pll_reset_sequencer_if (lock/soft_rst in,
//            pll_reset/sys_rst_n/locked/timeout_err/event_cnt out)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int RETRY_W       = DEF_RETRY_W
) (
    input logic                   clk,
    input logic                   rst_n,
    pll_reset_sequencer_if.slave  bus
);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    seq_state_t         state, state_nxt;
    logic [CNT_W-1:0]   timer, timer_nxt;
    logic [RETRY_W-1:0] event_cnt_q, event_cnt_nxt;
    logic               timeout_err_q, timeout_err_nxt;
    logic               pll_reset_q, sys_rst_n_q, locked_q;
    logic               lock_s;

    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer + 1'b1;
        event_cnt_nxt   = event_cnt_q;
        timeout_err_nxt = timeout_err_q;

        // soft_rst overrides whatever the current state would do this cycle,
        // including a coincident timeout, so nothing is recorded for it.
        if (bus.soft_rst) begin
            state_nxt = PLL_RST;
            timer_nxt = '0;
        end else begin
            unique case (state)
                PLL_RST: begin
                    if (timer == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = STABLE;
                        timer_nxt = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        state_nxt       = PLL_RST;
                        timer_nxt       = '0;
                        timeout_err_nxt = 1'b1;
                        event_cnt_nxt   = sat_inc(event_cnt_q);
                    end
                end
                STABLE: begin
                    // A dropout here is treated as a glitch: back to waiting,
                    // PLL not reset, event counter untouched.
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == STABLE_LAST) begin
                        state_nxt = RUN;
                        timer_nxt = '0;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt     = PLL_RST;
                        timer_nxt     = '0;
                        event_cnt_nxt = sat_inc(event_cnt_q);
                    end
                end
                default: begin
                    state_nxt = PLL_RST;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge the state does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PLL_RST;
            timer         <= '0;
            event_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            pll_reset_q   <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            event_cnt_q   <= event_cnt_nxt;
            timeout_err_q <= timeout_err_nxt;
            pll_reset_q   <= (state_nxt == PLL_RST);
            sys_rst_n_q   <= (state_nxt == RUN);
            locked_q      <= (state_nxt == RUN);
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.locked      = locked_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.event_cnt   = event_cnt_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Scoreboard bench: stimulus pushes each expected output change (cycle
//   number and output vector) into a queue; a monitor pops and compares on
//   every observed change of the output vector.
//   Cycle numbering: cyc = number of rising edges since rst_n release, so a
//   value "at cyc N" is what the outputs hold just after edge N.
module tb_pll_reset_sequencer;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int CNT_W         = 16;
    localparam int RETRY_W       = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.RETRY_W(RETRY_W)) bus();

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W),
        .RETRY_W       (RETRY_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // {pll_reset, sys_rst_n, locked, timeout_err, event_cnt[2:0]}
    function automatic logic [6:0] obs();
        return {bus.pll_reset, bus.sys_rst_n, bus.locked, bus.timeout_err, bus.event_cnt};
    endfunction

    function automatic logic [6:0] pack(input logic pr, input logic sr, input logic lk,
                                        input logic te, input logic [2:0] ev);
        return {pr, sr, lk, te, ev};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_at(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session(input logic lock);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rst_n        = 1'b0;
        bus.pll_lock = lock;
        bus.soft_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every change of the output vector must match the next expectation.
    initial begin : monitor
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       e;
        prev = 7'b1000000;
        forever begin
            @(negedge clk);
            cur = obs();
            if (!rst_n) begin
                prev = cur;
            end else if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_change at cyc %0d: got 0x%0h, expected 0x%0h", cyc, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("change_cycle_%0d", e.cyc), cyc, e.cyc);
                    check($sformatf("outputs_at_%0d", e.cyc), cur, e.val);
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.pll_lock = 1'b0;
        bus.soft_rst = 1'b0;

        // Lock arrives 3 cycles after pll_reset falls (edge 4): sampled at 8,
        // lock_s at 9, STABLE at 10, RUN after 8 stable cycles at 18.
        start_session(1'b0);
        expect_at(4,  pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at(18, pack(1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        wait_cyc(7);
        bus.pll_lock = 1'b1;

        // Lock loss in RUN: dropped after edge 25, seen at 28; PLL_RST 28..32.
        wait_cyc(25);
        expect_at(28, pack(1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at(32, pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        bus.pll_lock = 1'b0;
        wait_cyc(34);
        expect_at(45, pack(1'b0, 1'b1, 1'b1, 1'b0, 3'd1));
        bus.pll_lock = 1'b1;

        // soft_rst in RUN: PLL_RST at 51, WAIT_LOCK 55, STABLE 56, RUN 64.
        wait_cyc(50);
        expect_at(51, pack(1'b1, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at(55, pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
        expect_at(64, pack(1'b0, 1'b1, 1'b1, 1'b0, 3'd1));
        bus.soft_rst = 1'b1;
        wait_cyc(51);
        bus.soft_rst = 1'b0;
        wait_cyc(70);

        // Glitch in STABLE at stable count 5: STABLE 8, WAIT_LOCK 14, STABLE 15, RUN 23.
        start_session(1'b0);
        expect_at(4,  pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at(23, pack(1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        wait_cyc(5);
        bus.pll_lock = 1'b1;
        wait_cyc(11);
        bus.pll_lock = 1'b0;
        wait_cyc(12);
        bus.pll_lock = 1'b1;
        wait_cyc(30);

        // No lock: timeout n at cyc 24n, pll_reset low again at 24n+4;
        // event_cnt saturates at 7.
        start_session(1'b0);
        expect_at(4, pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        for (int n = 1; n <= 9; n++) begin
            expect_at(24 * n,     pack(1'b1, 1'b0, 1'b0, 1'b1, 3'((n > 7) ? 7 : n)));
            expect_at(24 * n + 4, pack(1'b0, 1'b0, 1'b0, 1'b1, 3'((n > 7) ? 7 : n)));
        end
        wait_cyc(24 * 9 + 10);

        // soft_rst on the timeout edge (24): no error, no count; next timeout at 48.
        start_session(1'b0);
        expect_at(4,  pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at(24, pack(1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at(28, pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at(48, pack(1'b1, 1'b0, 1'b0, 1'b1, 3'd1));
        expect_at(52, pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
        wait_cyc(23);
        bus.soft_rst = 1'b1;
        wait_cyc(24);
        bus.soft_rst = 1'b0;

        // Lock after 52 -> STABLE at 55; async reset between edges at cyc 58.
        wait_cyc(52);
        bus.pll_lock = 1'b1;
        wait_cyc(58);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_pll_reset",   bus.pll_reset,   1);
        check("async_sys_rst_n",   bus.sys_rst_n,   0);
        check("async_locked",      bus.locked,      0);
        check("async_timeout_err", bus.timeout_err, 0);
        check("async_event_cnt",   bus.event_cnt,   0);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();

        // Release with lock held high: lock_s at 2, WAIT_LOCK 4, STABLE 5, RUN 13.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_at(4,  pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        expect_at(13, pack(1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
        wait_cyc(20);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
